// File: rtl/muldiv_unit.sv
// Iterative MIPS mult/multu/div/divu unit with HI/LO registers.
// One shift-add or restoring-divide step per clock, followed by a sign-fixup cycle.
module muldiv_unit #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PW-1:0]    acc_q, acc_d;      // product, or {unused, dividend/quotient}
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;    // |A| for multiply, |B| for divide
  logic             is_div_q, is_div_d;
  logic             neg_a_q, neg_a_d;
  logic             neg_b_q, neg_b_d;
  logic             bz_q, bz_d;
  logic             busy_d, done_d, dz_d;
  logic [WIDTH-1:0] hi_d, lo_d;

  logic             signed_op, a_neg_in, b_neg_in;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   mul_add, mul_sum, div_shift, div_trial;
  logic [PW-1:0]    prod_fix;
  logic [WIDTH-1:0] quo_fix, rem_fix;

  // Operand magnitudes; |0x80000000| stays 0x80000000 as an unsigned value
  assign signed_op = ~op[0];
  assign a_neg_in  = signed_op & A[WIDTH-1];
  assign b_neg_in  = signed_op & B[WIDTH-1];
  assign a_mag     = a_neg_in ? -A : A;
  assign b_mag     = b_neg_in ? -B : B;

  // Iteration datapath
  assign mul_add   = acc_q[0] ? {1'b0, opnd_q} : '0;
  assign mul_sum   = {1'b0, acc_q[PW-1:WIDTH]} + mul_add;
  assign div_shift = {rem_q, acc_q[WIDTH-1]};
  assign div_trial = div_shift - {1'b0, opnd_q};

  // Sign fixup; with B==0 the remainder path reproduces the raw dividend
  assign prod_fix = (neg_a_q ^ neg_b_q) ? -acc_q : acc_q;
  assign quo_fix  = (neg_a_q ^ neg_b_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  assign rem_fix  = neg_a_q ? -rem_q : rem_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    rem_d    = rem_q;
    opnd_d   = opnd_q;
    is_div_d = is_div_q;
    neg_a_d  = neg_a_q;
    neg_b_d  = neg_b_q;
    bz_d     = bz_q;
    busy_d   = busy;
    done_d   = 1'b0;
    dz_d     = 1'b0;
    hi_d     = HI;
    lo_d     = LO;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          unique case (op)
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
              is_div_d = op[1];
              neg_a_d  = a_neg_in;
              neg_b_d  = b_neg_in;
              bz_d     = (B == '0);
              opnd_d   = op[1] ? b_mag : a_mag;
              acc_d    = {{WIDTH{1'b0}}, op[1] ? a_mag : b_mag};
              rem_d    = '0;
              cnt_d    = '0;
              busy_d   = 1'b1;
              state_d  = S_RUN;
            end
            OP_MTHI: begin
              hi_d   = A;
              done_d = 1'b1;
            end
            OP_MTLO: begin
              lo_d   = A;
              done_d = 1'b1;
            end
            default: ;
          endcase
        end
      end
      S_RUN: begin
        if (is_div_q) begin
          rem_d = div_trial[WIDTH] ? div_shift[WIDTH-1:0] : div_trial[WIDTH-1:0];
          acc_d = {acc_q[PW-1:WIDTH], acc_q[WIDTH-2:0], ~div_trial[WIDTH]};
        end else begin
          acc_d = {mul_sum, acc_q[WIDTH-1:1]};
        end
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) state_d = S_FIX;
      end
      S_FIX: begin
        if (is_div_q) begin
          hi_d = rem_fix;
          lo_d = bz_q ? '1 : quo_fix;
          dz_d = bz_q;
        end else begin
          hi_d = prod_fix[PW-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end
        cnt_d   = '0;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      rem_q    <= '0;
      opnd_q   <= '0;
      is_div_q <= 1'b0;
      neg_a_q  <= 1'b0;
      neg_b_q  <= 1'b0;
      bz_q     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      HI       <= '0;
      LO       <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      rem_q    <= rem_d;
      opnd_q   <= opnd_d;
      is_div_q <= is_div_d;
      neg_a_q  <= neg_a_d;
      neg_b_q  <= neg_b_d;
      bz_q     <= bz_d;
      busy     <= busy_d;
      done     <= done_d;
      div_zero <= dz_d;
      HI       <= hi_d;
      LO       <= lo_d;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed-vector and reference-model bench for muldiv_unit.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        busy, done, div_zero;
  logic [31:0] hi, lo;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] prev_hi = '0;
  logic [31:0] prev_lo = '0;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] ehi;
    logic [31:0] elo;
    logic        edz;
    string       name;
  } vec_t;

  vec_t vecs[15];

  muldiv_unit dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .A(a), .B(b),
    .busy(busy), .done(done), .div_zero(div_zero), .HI(hi), .LO(lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Issue one iterative op; poke >= 0 raises start (DIV) for one cycle mid-run.
  task automatic run_op(input logic [2:0] o, input logic [31:0] va, input logic [31:0] vb,
                        input logic [31:0] ehi, input logic [31:0] elo, input logic edz,
                        input string nm, input int poke);
    logic tim_ok;
    op = o; a = va; b = vb; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; a = $urandom; b = $urandom; op = 3'($urandom);
    tim_ok = busy && !done && (hi === prev_hi) && (lo === prev_lo);
    for (int k = 0; k < 32; k++) begin
      @(posedge clk); #1;
      start = (k == poke);
      if (k == poke) op = 3'd2;
      if (!busy || done || hi !== prev_hi || lo !== prev_lo) tim_ok = 1'b0;
    end
    @(posedge clk); #1;
    start = 1'b0;
    chk({nm, " timing"}, 32'(tim_ok && !busy && done), 32'd1);
    chk({nm, " HI"}, hi, ehi);
    chk({nm, " LO"}, lo, elo);
    chk({nm, " div_zero"}, 32'(div_zero), 32'(edz));
    prev_hi = ehi;
    prev_lo = elo;
  endtask

  task automatic model(input logic [2:0] o, input logic [31:0] va, input logic [31:0] vb,
                       output logic [31:0] ehi, output logic [31:0] elo, output logic edz);
    logic signed [63:0] sp;
    logic [63:0]        up;
    logic signed [31:0] sa, sb;
    sa = va; sb = vb; edz = 1'b0;
    case (o)
      3'd0: begin
        sp = 64'(sa) * 64'(sb);
        ehi = sp[63:32]; elo = sp[31:0];
      end
      3'd1: begin
        up = {32'd0, va} * {32'd0, vb};
        ehi = up[63:32]; elo = up[31:0];
      end
      3'd2: begin
        if (vb == 32'd0) begin
          ehi = va; elo = 32'hFFFF_FFFF; edz = 1'b1;
        end else if (va == 32'h8000_0000 && vb == 32'hFFFF_FFFF) begin
          ehi = 32'd0; elo = 32'h8000_0000;
        end else begin
          elo = sa / sb; ehi = sa % sb;
        end
      end
      default: begin
        if (vb == 32'd0) begin
          ehi = va; elo = 32'hFFFF_FFFF; edz = 1'b1;
        end else begin
          elo = va / vb; ehi = va % vb;
        end
      end
    endcase
  endtask

  initial begin
    logic [31:0] ehi, elo, ra, rb;
    logic        edz, seen;
    logic [2:0]  ro;

    vecs[0]  = '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, "multu max"};
    vecs[1]  = '{3'd0, 32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0, "mult -3*5"};
    vecs[2]  = '{3'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0, "mult minmin"};
    vecs[3]  = '{3'd2, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, "div -7/2"};
    vecs[4]  = '{3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0, "div min/-1"};
    vecs[5]  = '{3'd3, 32'h0000_1234, 32'd0,         32'h0000_1234, 32'hFFFF_FFFF, 1'b1, "divu by0"};
    vecs[6]  = '{3'd3, 32'd100,       32'd7,         32'd2,         32'd14,         1'b0, "divu 100/7"};
    vecs[7]  = '{3'd1, 32'd2,         32'd3,         32'd0,         32'd6,          1'b0, "multu 2*3"};
    vecs[8]  = '{3'd2, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 1'b0, "div 7/-2"};
    vecs[9]  = '{3'd0, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 1'b0, "mult 7*-1"};
    vecs[10] = '{3'd2, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b1, "div -5/0"};
    vecs[11] = '{3'd3, 32'hFFFF_FFFF, 32'h10,        32'h0000_000F, 32'h0FFF_FFFF, 1'b0, "divu max/16"};
    vecs[12] = '{3'd1, 32'h1234_5678, 32'h100,       32'h0000_0012, 32'h3456_7800, 1'b0, "multu shift"};
    vecs[13] = '{3'd0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'h0000_0001, 1'b0, "mult maxmax"};
    vecs[14] = '{3'd2, 32'hFFFF_FFF8, 32'hFFFF_FFFD, 32'hFFFF_FFFE, 32'd2,          1'b0, "div -8/-3"};

    rst_n = 1'b0; start = 1'b0; op = '0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset div_zero", 32'(div_zero), 32'd0);
    chk("reset HI", hi, 32'd0);
    chk("reset LO", lo, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Back-to-back directed vectors
    for (int i = 0; i < 15; i++)
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].ehi, vecs[i].elo, vecs[i].edz, vecs[i].name, -1);

    // start while busy must be ignored without disturbing the result or timing
    run_op(3'd1, 32'd9, 32'd11, 32'd0, 32'd99, 1'b0, "multu poke", 9);
    run_op(3'd3, 32'd50, 32'd8, 32'd2, 32'd6, 1'b0, "divu poke fix", 31);

    // MTHI / MTLO / reserved ops
    op = 3'd4; a = 32'hDEAD_BEEF; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("mthi HI", hi, 32'hDEAD_BEEF);
    chk("mthi LO", lo, prev_lo);
    chk("mthi done/busy", 32'({done, busy, div_zero}), 32'b100);
    prev_hi = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    chk("mthi done drop", 32'({done, busy}), 32'b00);
    op = 3'd5; a = 32'hCAFE_F00D; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("mtlo LO", lo, 32'hCAFE_F00D);
    chk("mtlo HI", hi, prev_hi);
    chk("mtlo done/busy", 32'({done, busy}), 32'b10);
    prev_lo = 32'hCAFE_F00D;
    for (int r = 6; r < 8; r++) begin
      op = 3'(r); a = 32'h1111_2222; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      chk("reserved op flags", 32'({done, busy}), 32'b00);
      chk("reserved op HI", hi, prev_hi);
      chk("reserved op LO", lo, prev_lo);
    end

    // Reset in the middle of an operation discards it
    op = 3'd1; a = 32'd2; b = 32'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    op = 3'd2; a = 32'd100; b = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("midrun start busy", 32'(busy), 32'd1);
    repeat (9) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midreset busy", 32'(busy), 32'd0);
    chk("midreset done", 32'(done), 32'd0);
    chk("midreset HI", hi, 32'd0);
    chk("midreset LO", lo, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    prev_hi = '0; prev_lo = '0;
    seen = 1'b0;
    for (int k = 0; k < 60; k++) begin
      @(posedge clk); #1;
      if (done || busy) seen = 1'b1;
    end
    chk("no done after reset", 32'(seen), 32'd0);
    run_op(3'd3, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, "divu after reset", -1);

    // Random ops against the reference model
    for (int i = 0; i < 200; i++) begin
      ro = 3'($urandom_range(0, 3));
      ra = $urandom;
      rb = ($urandom_range(0, 15) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 3) == 0) rb = rb >> $urandom_range(8, 31);
      model(ro, ra, rb, ehi, elo, edz);
      run_op(ro, ra, rb, ehi, elo, edz, $sformatf("rand%0d op%0d %h %h", i, ro, ra, rb), -1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
